// File: rtl/address_arbiter.sv
// Round-robin arbiter sharing one histogram-memory address port among NREQ
// address generators, with a forced idle gap after each issue.
module address_arbiter #(
  parameter int NREQ        = 4,
  parameter int ADDRESSBITS = 8,
  parameter int GAP         = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*ADDRESSBITS-1:0] reqAddress,
  input  logic                        storageReady,
  output logic [NREQ-1:0]             grant,
  output logic [ADDRESSBITS-1:0]      address,
  output logic                        newAddress,
  output logic                        busy,
  output logic [15:0]                 issueCount
);

  localparam int unsigned N        = NREQ;
  localparam int unsigned PTRW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]  GAP_INIT = 4'(GAP);

  typedef enum logic {
    ST_IDLE,
    ST_GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              gap_cnt_q, gap_cnt_d;
  logic [PTRW-1:0]         ptr_q, ptr_d;
  logic [NREQ-1:0]         grant_q, grant_d;
  logic [ADDRESSBITS-1:0]  address_q, address_d;
  logic                    new_address_q, new_address_d;
  logic                    busy_q, busy_d;
  logic [15:0]             issue_count_q, issue_count_d;

  logic                    found;
  logic [PTRW-1:0]         win_idx;
  logic [PTRW-1:0]         cand_idx;

  // First requester with req high, searching from ptr upward modulo NREQ.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand_idx = PTRW'((32'(ptr_q) + i) % N);
      if (!found && req[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    ptr_d         = ptr_q;
    grant_d       = '0;
    address_d     = address_q;
    new_address_d = 1'b0;
    busy_d        = busy_q;
    issue_count_d = issue_count_q;
    case (state_q)
      ST_IDLE: begin
        if (storageReady && found) begin
          address_d        = reqAddress[32'(win_idx)*ADDRESSBITS +: ADDRESSBITS];
          new_address_d    = 1'b1;
          grant_d[win_idx] = 1'b1;
          ptr_d            = PTRW'((32'(win_idx) + 1) % N);
          gap_cnt_d        = GAP_INIT;
          state_d          = ST_GAP;
          busy_d           = 1'b1;
          if (issue_count_q != 16'hFFFF) begin
            issue_count_d = issue_count_q + 16'd1;
          end
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - 4'd1;
        if (gap_cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      gap_cnt_q     <= '0;
      ptr_q         <= '0;
      grant_q       <= '0;
      address_q     <= '0;
      new_address_q <= 1'b0;
      busy_q        <= 1'b0;
      issue_count_q <= '0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      address_q     <= address_d;
      new_address_q <= new_address_d;
      busy_q        <= busy_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign grant      = grant_q;
  assign address    = address_q;
  assign newAddress = new_address_q;
  assign busy       = busy_q;
  assign issueCount = issue_count_q;

endmodule

// File: tb/tb_address_arbiter.sv
// Directed bench for address_arbiter: per-cycle vector table plus hand-written
// mid-gap reset and counter saturation sequences.
module tb_address_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] reqAddress;
  logic        storageReady;
  logic [3:0]  grant;
  logic [7:0]  address;
  logic        newAddress;
  logic        busy;
  logic [15:0] issueCount;

  int total;
  int bad;

  address_arbiter #(
    .NREQ(4),
    .ADDRESSBITS(8),
    .GAP(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .reqAddress(reqAddress),
    .storageReady(storageReady),
    .grant(grant),
    .address(address),
    .newAddress(newAddress),
    .busy(busy),
    .issueCount(issueCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs applied before an edge, outputs expected just after that edge.
  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] addrs;
    logic        sr;
    logic [3:0]  grant;
    logic [7:0]  addr;
    logic        nw;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[64];
  int   n_vec;

  localparam logic [31:0] ADDR_A = 32'h4332215A;
  localparam logic [31:0] ADDR_B = 32'h43322110;

  task automatic add(input logic rst, input logic [3:0] rq, input logic [31:0] ad,
                     input logic sr, input logic [3:0] g, input logic [7:0] a,
                     input logic nw, input logic b, input logic [15:0] c);
    vecs[n_vec] = '{rst: rst, req: rq, addrs: ad, sr: sr, grant: g, addr: a,
                    nw: nw, busy: b, cnt: c};
    n_vec++;
  endtask

  // One issue edge followed by the two gap edges (busy high, then low).
  task automatic add_issue(input logic [3:0] rq, input logic [31:0] ad, input logic [3:0] g,
                           input logic [7:0] a, input logic [15:0] c, input logic [3:0] gap_rq);
    add(1'b0, rq, ad, 1'b1, g, a, 1'b1, 1'b1, c);
    add(1'b0, gap_rq, ad, 1'b1, 4'b0000, a, 1'b0, 1'b1, c);
    add(1'b0, gap_rq, ad, 1'b1, 4'b0000, a, 1'b0, 1'b0, c);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] g, input logic [7:0] a,
                            input logic nw, input logic b, input logic [15:0] c);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".address"}, 32'(address), 32'(a));
    check({tag, ".newAddress"}, 32'(newAddress), 32'(nw));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".issueCount"}, 32'(issueCount), 32'(c));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n_vec = 0;

    // Single requester: issues on edges 1, 4, 7.
    add_issue(4'b0001, ADDR_A, 4'b0001, 8'h5A, 16'd1, 4'b0001);
    add_issue(4'b0001, ADDR_A, 4'b0001, 8'h5A, 16'd2, 4'b0001);
    add_issue(4'b0001, ADDR_A, 4'b0001, 8'h5A, 16'd3, 4'b0001);
    add(1'b1, 4'b0000, ADDR_B, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 16'd0);
    // Round-robin fairness with all four requesting.
    add_issue(4'b1111, ADDR_B, 4'b0001, 8'h10, 16'd1, 4'b1111);
    add_issue(4'b1111, ADDR_B, 4'b0010, 8'h21, 16'd2, 4'b1111);
    add_issue(4'b1111, ADDR_B, 4'b0100, 8'h32, 16'd3, 4'b1111);
    add_issue(4'b1111, ADDR_B, 4'b1000, 8'h43, 16'd4, 4'b1111);
    add_issue(4'b1111, ADDR_B, 4'b0001, 8'h10, 16'd5, 4'b1111);
    // Pointer skip: after requester 1 wins, 2 and 3 are idle so 0 wins, then 1.
    add_issue(4'b1111, ADDR_B, 4'b0010, 8'h21, 16'd6, 4'b0011);
    add_issue(4'b0011, ADDR_B, 4'b0001, 8'h10, 16'd7, 4'b0011);
    add_issue(4'b0011, ADDR_B, 4'b0010, 8'h21, 16'd8, 4'b0000);
    add(1'b1, 4'b0000, ADDR_B, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 16'd0);
    // Backpressure: request held pending while storageReady is low.
    for (int k = 0; k < 5; k++)
      add(1'b0, 4'b0100, ADDR_B, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 16'd0);
    add_issue(4'b0100, ADDR_B, 4'b0100, 8'h32, 16'd1, 4'b0000);

    reset        = 1'b1;
    req          = '0;
    reqAddress   = '0;
    storageReady = 1'b0;
    step();
    check_outs("reset_state", 4'b0000, 8'h00, 1'b0, 1'b0, 16'd0);

    for (int i = 0; i < n_vec; i++) begin
      reset        = vecs[i].rst;
      req          = vecs[i].req;
      reqAddress   = vecs[i].addrs;
      storageReady = vecs[i].sr;
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].addr, vecs[i].nw,
                 vecs[i].busy, vecs[i].cnt);
    end

    // Reset asserted mid-gap clears everything at once; first issue after
    // release happens on the first edge.
    req          = 4'b0001;
    reqAddress   = ADDR_A;
    storageReady = 1'b1;
    step();
    check_outs("rst_pre_issue", 4'b0001, 8'h5A, 1'b1, 1'b1, 16'd2);
    req = 4'b0000;
    step();
    check_outs("rst_pre_gap", 4'b0000, 8'h5A, 1'b0, 1'b1, 16'd2);
    #2 reset = 1'b1;
    #1 check_outs("rst_async", 4'b0000, 8'h00, 1'b0, 1'b0, 16'd0);
    step();
    check_outs("rst_hold1", 4'b0000, 8'h00, 1'b0, 1'b0, 16'd0);
    step();
    check_outs("rst_hold2", 4'b0000, 8'h00, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;
    req   = 4'b1000;
    step();
    check_outs("rst_first_issue", 4'b1000, 8'h43, 1'b1, 1'b1, 16'd1);
    req = 4'b0000;
    step();
    step();
    step();
    check_outs("rst_settle", 4'b0000, 8'h43, 1'b0, 1'b0, 16'd1);

    // Saturation: preload near the limit, then keep issuing.
    force dut.issue_count_q = 16'hFFFD;
    step();
    release dut.issue_count_q;
    step();
    check("sat_preload", 32'(issueCount), 32'h0000FFFD);
    req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      step();
      check_outs($sformatf("sat_issue%0d", k), 4'b0001, 8'h5A, 1'b1, 1'b1,
                 (k == 0) ? 16'hFFFE : 16'hFFFF);
      step();
      check($sformatf("sat_gap%0d_nw", k), 32'(newAddress), 32'd0);
      step();
      check($sformatf("sat_idle%0d_busy", k), 32'(busy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/address_arbiter.md
# address_arbiter

Round-robin scheduler that shares the single histogram-memory address port between NREQ address generators. Each generator presents an address with a request; the arbiter picks one winner when the memory signals storageReady. It then drives the memory's address/newAddress pair, returns a one-cycle grant to the winner, and enforces a minimum spacing between issues so the memory's read-modify-write cycle can complete.

## Interface
- NREQ, 4, number of requesters (2..8)
- ADDRESSBITS, 8, memory address width; the header value overrides the default
- GAP, 2, idle cycles forced after each issue (1..15; 0 is illegal)
- clock  input  1  rising-edge clock, the only clock
- reset  input  1  asynchronous, active-high; clears all state immediately
- req  input  NREQ  request bit i; held high with a stable address until granted
- reqAddress  input  NREQ*ADDRESSBITS  address for requester i at bits [i*ADDRESSBITS +: ADDRESSBITS]
- storageReady  input  1  memory can accept an address at this edge
- grant  output reg  NREQ  one-hot, one-cycle pulse to the winning requester
- address  output reg  ADDRESSBITS  address presented to memory
- newAddress  output reg  1  one-cycle strobe qualifying address
- busy  output reg  1  high while the gap counter is nonzero
- issueCount  output reg  16  total issues since reset; saturates at 16'hFFFF

## Operation
- States:
  - IDLE: eligible to issue.
  - GAP: counting down; no issue is possible.
- Rotating priority pointer ptr, log2(NREQ) bits, reset value 0.
- Search order: requesters ptr, ptr+1, …, ptr+NREQ-1, all modulo NREQ. The first one with req high wins.
- Issue condition: state==IDLE, storageReady==1, and |req==1. At that edge:
  - address <= winner's reqAddress slice; newAddress <= 1; grant <= one-hot(winner).
  - ptr <= (winner+1) mod NREQ.
  - gap counter <= GAP; state <= GAP; busy <= 1.
  - issueCount increments, but only if it is not already at 16'hFFFF.
- When the issue condition is false at an edge:
  - newAddress <= 0 and grant <= 0.
  - address holds its last value.
  - ptr does not move.
- GAP state:
  - The counter decrements each edge.
  - The edge where the counter goes 1→0 returns state to IDLE and sets busy <= 0.
  - storageReady and req are ignored while in GAP.
- Requester contract: a requester samples grant high and, on that same edge, drops req or advances to its next address. A request still high in IDLE after the gap has expired is treated as a new request.
- Requests with storageReady low are held pending with no grant. Priority is evaluated at the edge where storageReady rises.
- Reset, asserted at any time including mid-GAP, forces:
  - grant=0, address=0, newAddress=0, busy=0, issueCount=0, ptr=0, state=IDLE.
  - Any in-flight grant is lost; requesters re-request after reset.

## Timing
- Latency: a request and storageReady high before edge t produce address/newAddress/grant valid during cycle t→t+1. That is one cycle of latency, with all outputs registered.
- Maximum issue rate: one issue per GAP+1 cycles. With GAP=2, issues fall on edges t, t+3, t+6, …
- busy is high for exactly GAP cycles after each issue edge.
- newAddress and grant are never high for two consecutive cycles, because GAP≥1.
- No combinational path from any input to any output.

## Test plan
- Single requester: NREQ=4, GAP=2, req=4'b0001, addr0=8'h5A, storageReady=1 constant.
  - Issues with address=8'h5A land on edges 1, 4, 7.
  - Each issue has grant=4'b0001 and newAddress high for 1 cycle.
  - issueCount reaches 3 after edge 7.
- Round-robin fairness: req=4'b1111 held continuously, ptr=0, addresses 8'h10/8'h21/8'h32/8'h43.
  - Grants are 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart.
  - Address sequence is 10, 21, 32, 43, 10.
- Pointer skip: after requester 1 is granted, req=4'b0011.
  - Next grant goes to requester 0, because the search order is 2, 3, 0.
  - ptr then becomes 1.
- Backpressure: storageReady=0 for 5 cycles with req=4'b0100.
  - grant, newAddress, and issueCount stay 0.
  - On the first edge with storageReady=1, grant=4'b0100 and address equals addr2.
- Reset mid-gap: issue once, then assert reset one cycle later for 2 cycles.
  - All outputs read 0 during reset.
  - With req=4'b1000 after release, the first issue happens at the first edge, not after the remaining gap, and issueCount=1.
- Saturation: preload issueCount near the limit by running 65 540 issues, or force the register in the bench.
  - issueCount holds at 16'hFFFF.
  - Issues continue normally.
